// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the uC data SRAM: uC has priority, the host wins
// conflicts after a bounded wait, and host_lock gives the host exclusive access.
module sram_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uc_req,
  input  logic              uc_we,
  input  logic [ADDR_W-1:0] uc_addr,
  input  logic [DATA_W-1:0] uc_wdata,
  output logic              uc_gnt,
  output logic              uc_rvalid,
  output logic [DATA_W-1:0] uc_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  logic [3:0] starve_cnt;
  logic       uc_own;
  logic       host_own;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    uc_gnt   = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (host_req && (host_lock || !uc_req || starve_cnt == MAX_WAIT)) begin
        host_gnt = 1'b1;
      end else if (uc_req && !host_lock) begin
        uc_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = uc_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (uc_gnt) begin
      mem_we    = uc_we;
      mem_addr  = uc_addr;
      mem_wdata = uc_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= '0;
      conflict_cnt <= '0;
      uc_own       <= 1'b0;
      host_own     <= 1'b0;
    end else begin
      uc_own   <= uc_gnt & ~uc_we;
      host_own <= host_gnt & ~host_we;

      if (host_gnt || !host_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt < MAX_WAIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (uc_req && host_req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  // SRAM data is shared; only the owner of last cycle's read sees it.
  assign uc_rvalid   = uc_own;
  assign host_rvalid = host_own;
  assign uc_rdata    = uc_own   ? mem_rdata : '0;
  assign host_rdata  = host_own ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a queue of
// expected read returns checked one cycle after each grant.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        uc_req, uc_we, host_req, host_we, host_lock;
  logic [7:0]  uc_addr, uc_wdata, host_addr, host_wdata;
  logic        uc_gnt, uc_rvalid, host_gnt, host_rvalid;
  logic [7:0]  uc_rdata, host_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  logic [7:0] sram    [256];
  logic [7:0] ref_mem [256];

  typedef struct packed {
    logic       uc;
    logic       host;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  sram_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .uc_req(uc_req), .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_gnt(uc_gnt), .uc_rvalid(uc_rvalid), .uc_rdata(uc_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check the combinational grant/memory drive,
  // record the expected read return, then check last cycle's return.
  task automatic cyc(input logic r, input logic ureq, input logic uwe,
                     input logic [7:0] uaddr, input logic [7:0] uwd,
                     input logic hreq, input logic hwe,
                     input logic [7:0] haddr, input logic [7:0] hwd,
                     input logic lock, input logic exp_u, input logic exp_h);
    rd_exp_t e;
    rst = r; uc_req = ureq; uc_we = uwe; uc_addr = uaddr; uc_wdata = uwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    host_lock = lock;
    #2;
    chk("uc_gnt", 32'(uc_gnt), 32'(exp_u));
    chk("host_gnt", 32'(host_gnt), 32'(exp_h));
    chk("mem_en", 32'(mem_en), 32'(exp_u | exp_h));
    chk("mem_we", 32'(mem_we), exp_h ? 32'(hwe) : exp_u ? 32'(uwe) : 32'd0);
    chk("mem_addr", 32'(mem_addr), exp_h ? 32'(haddr) : exp_u ? 32'(uaddr) : 32'd0);
    chk("mem_wdata", 32'(mem_wdata), exp_h ? 32'(hwd) : exp_u ? 32'(uwd) : 32'd0);
    e = '0;
    if (exp_h) begin
      if (hwe) ref_mem[haddr] = hwd;
      else if (!r) e = '{uc: 1'b0, host: 1'b1, data: ref_mem[haddr]};
    end else if (exp_u) begin
      if (uwe) ref_mem[uaddr] = uwd;
      else if (!r) e = '{uc: 1'b1, host: 1'b0, data: ref_mem[uaddr]};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("uc_rvalid", 32'(uc_rvalid), 32'(e.uc));
      chk("uc_rdata", 32'(uc_rdata), e.uc ? 32'(e.data) : 32'd0);
      chk("host_rvalid", 32'(host_rvalid), 32'(e.host));
      chk("host_rdata", 32'(host_rdata), e.host ? 32'(e.data) : 32'd0);
    end
  endtask

  task automatic idle(input logic r);
    cyc(r, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    sram[8'h12]    = 8'hA5;
    ref_mem[8'h12] = 8'hA5;
    mem_rdata      = 8'h00;

    // Reset state.
    idle(1'b1);
    chk("conflict_reset", 32'(conflict_cnt), 32'd0);
    idle(1'b0);

    // Single uC read of 0x12.
    cyc(1'b0, 1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // Host write 0x3C to 0x40, then read it back.
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, 8'h3C, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b1);

    // Back-to-back reads with owners alternating each cycle.
    cyc(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("conflict_none", 32'(conflict_cnt), 32'd0);

    // Starvation bound: host wins cycles 5 and 10.
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0,
          !(i == 5 || i == 10), (i == 5 || i == 10));
    end
    chk("conflict_10", 32'(conflict_cnt), 32'd10);

    // Host lock: host granted every cycle, uC locked out even when alone.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'(8'h50 + i), 8'h00, 1'b1, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("conflict_18", 32'(conflict_cnt), 32'd18);

    // Reset mid-read: a read requested during reset is never granted or returned.
    cyc(1'b0, 1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h12, 8'h77, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("conflict_after_rst", 32'(conflict_cnt), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Counter saturation with continuous conflicting writes to a scratch address.
    idle(1'b1);
    rst = 1'b0; uc_req = 1'b1; uc_we = 1'b1; uc_addr = 8'hFF; uc_wdata = 8'h11;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'hFF; host_wdata = 8'h22;
    host_lock = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("conflict_fffe", 32'(conflict_cnt), 32'h0000FFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    chk("conflict_sat", 32'(conflict_cnt), 32'h0000FFFF);
    idle(1'b0);
    chk("conflict_hold", 32'(conflict_cnt), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
